// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the RV32IM execute stage.
// Covers the instruction class/id encodings, the MUL/DIV FSM states and the writeback payload.
package ex_stage_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MD_ITERS     = 32;
    localparam int unsigned CNT_W        = $clog2(MD_ITERS);
    localparam int unsigned SHAMT_W      = $clog2(XLEN);
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned STALL_W      = 6;
    localparam int unsigned STALL_EX_BIT = 3;
    localparam int unsigned INST_IDX_W   = 5;
    localparam int unsigned INST_TYPE_W  = 3;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic NO_STALL   = 1'b0;

    localparam logic [XLEN-1:0] SIGN_MIN = XLEN'(1) << (XLEN - 1);

    typedef enum logic [INST_TYPE_W-1:0] {
        TYPE_NOP    = 3'd0,
        TYPE_ALU    = 3'd1,
        TYPE_MULDIV = 3'd2
    } inst_type_e;

    typedef enum logic [INST_IDX_W-1:0] {
        ID_NOP    = 5'd0,
        ID_ADD    = 5'd1,
        ID_SUB    = 5'd2,
        ID_SLL    = 5'd3,
        ID_SLT    = 5'd4,
        ID_SLTU   = 5'd5,
        ID_XOR    = 5'd6,
        ID_SRL    = 5'd7,
        ID_SRA    = 5'd8,
        ID_OR     = 5'd9,
        ID_AND    = 5'd10,
        ID_LUI    = 5'd11,
        ID_MUL    = 5'd12,
        ID_MULH   = 5'd13,
        ID_MULHSU = 5'd14,
        ID_MULHU  = 5'd15,
        ID_DIV    = 5'd16,
        ID_DIVU   = 5'd17,
        ID_REM    = 5'd18,
        ID_REMU   = 5'd19
    } inst_idx_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic                 rd_e;
        logic [REG_IDX_W-1:0] rd_idx;
        logic [XLEN-1:0]      rd_data;
    } wb_t;

    // True for the eight RV32M operations handled by the iterative unit.
    function automatic logic is_md_op(input logic [INST_IDX_W-1:0] idx);
        return (idx >= INST_IDX_W'(ID_MUL)) && (idx <= INST_IDX_W'(ID_REMU));
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// magnitudes in the datapath with a single sign fix-up on the final step.
module ex_stage_muldiv
    import ex_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [INST_IDX_W-1:0] op_i,
    input  logic [XLEN-1:0]       a_i,
    input  logic [XLEN-1:0]       b_i,
    input  logic                  hold_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o
);

    localparam int unsigned DW = 2 * XLEN;

    md_state_e        state_q;
    inst_idx_e        op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    acc_q;
    logic [XLEN-1:0]  b_q;
    logic             neg_q;
    logic [XLEN-1:0]  result_q;

    inst_idx_e       op_in;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_in;
    logic            rem_in;
    logic            neg_in;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] special_res;

    // Operand decode at start: signedness, magnitudes and the short-circuit divide cases.
    always_comb begin
        op_in       = inst_idx_e'(op_i);
        a_signed    = op_in inside {ID_MULH, ID_MULHSU, ID_DIV, ID_REM};
        b_signed    = op_in inside {ID_MULH, ID_DIV, ID_REM};
        div_in      = op_in inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
        rem_in      = op_in inside {ID_REM, ID_REMU};
        a_neg       = a_signed & a_i[XLEN-1];
        b_neg       = b_signed & b_i[XLEN-1];
        a_abs       = a_neg ? (XLEN'(0) - a_i) : a_i;
        b_abs       = b_neg ? (XLEN'(0) - b_i) : b_i;
        neg_in      = rem_in ? a_neg : (a_neg ^ b_neg);
        div_zero    = div_in && (b_i == '0);
        div_ovf     = (op_in inside {ID_DIV, ID_REM}) && (a_i == SIGN_MIN) && (b_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = rem_in ? a_i : '1;
        end else if (div_ovf) begin
            special_res = rem_in ? '0 : SIGN_MIN;
        end
    end

    logic            op_is_div;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_trial;
    logic [DW-1:0]   step_acc;

    // One iteration: low half of acc holds multiplier/quotient, high half the partial product/remainder.
    always_comb begin
        op_is_div = op_q inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
        mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
        div_trial = acc_q[DW-1:XLEN-1] - {1'b0, b_q};
        if (op_is_div) begin
            if (div_trial[XLEN]) begin
                step_acc = {acc_q[DW-2:0], 1'b0};
            end else begin
                step_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [DW-1:0]   prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] final_res;

    // Sign correction and half selection applied to the last step's accumulator.
    always_comb begin
        prod      = neg_q ? (DW'(0) - step_acc) : step_acc;
        quot      = step_acc[XLEN-1:0];
        rem       = step_acc[DW-1:XLEN];
        final_res = '0;
        case (op_q)
            ID_MUL:                       final_res = prod[XLEN-1:0];
            ID_MULH, ID_MULHSU, ID_MULHU: final_res = prod[DW-1:XLEN];
            ID_DIV, ID_DIVU:              final_res = neg_q ? (XLEN'(0) - quot) : quot;
            ID_REM, ID_REMU:              final_res = neg_q ? (XLEN'(0) - rem) : rem;
            default:                      final_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i == RST_ENABLE) begin
            state_q  <= MD_IDLE;
            op_q     <= ID_NOP;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        op_q  <= op_in;
                        cnt_q <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= MD_DONE;
                        end else begin
                            acc_q   <= {XLEN'(0), a_abs};
                            b_q     <= b_abs;
                            neg_q   <= neg_in;
                            state_q <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
                        result_q <= final_res;
                        state_q  <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    // Leaving DONE lines up with ID_EX loading the next instruction.
                    if (hold_i == NO_STALL) begin
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy_o   = (rst_n_i != RST_ENABLE) &&
                      (((state_q == MD_IDLE) && start_i) || (state_q == MD_BUSY));
    assign done_o   = (rst_n_i != RST_ENABLE) && (state_q == MD_DONE);
    assign result_o = result_q;

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU, iterative MUL/DIV unit and the writeback/stall mux.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [STALL_W-1:0]     stall_in,
    input  logic                   rdE_in,
    input  logic [REG_IDX_W-1:0]   rdIdx_in,
    input  logic [INST_IDX_W-1:0]  instIdx_in,
    input  logic [INST_TYPE_W-1:0] instType_in,
    input  logic [XLEN-1:0]        rs1Data_in,
    input  logic [XLEN-1:0]        rs2Data_in,
    output logic                   rdE_out,
    output logic [REG_IDX_W-1:0]   rdIdx_out,
    output logic [XLEN-1:0]        rdData_out,
    output logic                   stallReq_out
);

    // Only the EX hold bit matters here; the rest of the vector belongs to other stages.
    logic stall_unused;
    assign stall_unused = ^(stall_in & ~(STALL_W'(1) << STALL_EX_BIT));

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               alu_valid;

    assign shamt = rs2Data_in[SHAMT_W-1:0];

    always_comb begin
        alu_res   = '0;
        alu_valid = 1'b1;
        case (inst_idx_e'(instIdx_in))
            ID_ADD:  alu_res = rs1Data_in + rs2Data_in;
            ID_SUB:  alu_res = rs1Data_in - rs2Data_in;
            ID_SLL:  alu_res = rs1Data_in << shamt;
            ID_SLT:  alu_res = XLEN'($signed(rs1Data_in) < $signed(rs2Data_in));
            ID_SLTU: alu_res = XLEN'(rs1Data_in < rs2Data_in);
            ID_XOR:  alu_res = rs1Data_in ^ rs2Data_in;
            ID_SRL:  alu_res = rs1Data_in >> shamt;
            ID_SRA:  alu_res = XLEN'($signed(rs1Data_in) >>> shamt);
            ID_OR:   alu_res = rs1Data_in | rs2Data_in;
            ID_AND:  alu_res = rs1Data_in & rs2Data_in;
            ID_LUI:  alu_res = rs2Data_in;
            default: alu_valid = 1'b0;
        endcase
    end

    logic            is_alu;
    logic            md_start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    assign is_alu   = (inst_type_e'(instType_in) == TYPE_ALU) && alu_valid;
    assign md_start = (inst_type_e'(instType_in) == TYPE_MULDIV) && is_md_op(instIdx_in);

    ex_stage_muldiv u_muldiv (
        .clk_i    (clk_in),
        .rst_n_i  (rst_in),
        .start_i  (md_start),
        .op_i     (instIdx_in),
        .a_i      (rs1Data_in),
        .b_i      (rs2Data_in),
        .hold_i   (stall_in[STALL_EX_BIT]),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Writeback mux: nothing leaves EX while in reset or while a MUL/DIV is still iterating.
    wb_t wb;

    always_comb begin
        wb = '0;
        if (rst_in != RST_ENABLE) begin
            if (is_alu) begin
                wb = '{rd_e: rdE_in, rd_idx: rdIdx_in, rd_data: alu_res};
            end else if (md_start && md_done) begin
                wb = '{rd_e: rdE_in, rd_idx: rdIdx_in, rd_data: md_result};
            end
        end
    end

    assign rdE_out      = wb.rd_e;
    assign rdIdx_out    = wb.rd_idx;
    assign rdData_out   = wb.rd_data;
    assign stallReq_out = md_busy;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline.
- Consumes the ID_EX pipeline register outputs and produces the writeback triple (rdE, rdIdx, rdData) for the EX_MEM register.
- Single-cycle ALU for RV32I ops.
- Iterative multi-cycle unit for RV32M MUL/DIV/REM. While busy, it raises a stall request to the pipeline controller.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_ITERS, 32, iterations per multiply/divide operation.

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  synchronous reset, active-low (`rstEnable = 1'b0)
- stall_in  input  `stallRange (6)  controller stall vector; bit 3 = EX stage held
- rdE_in  input  1  destination write enable from ID_EX
- rdIdx_in  input  5  destination register index
- instIdx_in  input  `instIdxRange  operation id (`idADD, `idMUL, `idDIV, ...)
- instType_in  input  `instTypeRange  class (`typeNOP, `typeALU, `typeMULDIV, ...)
- rs1Data_in  input  32  operand A
- rs2Data_in  input  32  operand B; immediate already substituted by ID
- rdE_out  output  1  writeback enable to EX_MEM
- rdIdx_out  output  5  writeback index
- rdData_out  output  32  result
- stallReq_out  output  1  request to stall stages 0..3 and bubble EX_MEM

Behaviour:
- Reset, applied when rst_in=0 at a clock edge:
  - FSM goes to IDLE; counter, accumulator and operand registers are cleared.
  - rdE_out=0, rdIdx_out=0, rdData_out=0, stallReq_out=0.
  - Reset mid-operation abandons the operation with no partial result.
- ALU path (typeALU):
  - Outputs are combinational from the inputs; zero added latency.
  - ADD/SUB use modulo 2^32 arithmetic.
  - Shifts use rs2[4:0] only. SRA is arithmetic.
  - SLT is signed; SLTU is unsigned. Results are 0/1, zero-extended.
  - XOR/OR/AND operate bitwise. LUI passes rs2 through.
- typeNOP or unknown instIdx: rdE_out=0, rdIdx_out=0, rdData_out=0.
- MULDIV FSM states: IDLE, BUSY, DONE.
  - IDLE with typeMULDIV input:
    - stallReq_out=1 combinationally.
    - Next edge: operands are latched as absolute values with sign flags for signed ops, cnt=0, state goes to BUSY.
    - Special cases go directly to DONE instead:
      - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
      - Signed overflow (0x80000000 / -1): DIV gives 0x80000000; REM gives 0.
  - BUSY:
    - stallReq_out=1. One shift-add (MUL*) or restoring shift-subtract (DIV*) step per cycle; cnt increments each step.
    - After step MD_ITERS-1, the final sign correction is applied and state goes to DONE.
  - DONE:
    - stallReq_out=0. rdData_out is the held result; rdE_out/rdIdx_out come from the inputs, which are still held by ID_EX.
    - Exits to IDLE on the first edge where stall_in[3]=`NoStall. If downstream stalls EX, DONE and the result are held.
- MUL returns the low 32 bits. MULH/MULHSU/MULHU return the high 32 bits of the 64-bit product, with signedness per the RV32M spec.
- Latency (input presented to result visible):
  - Normal: MD_ITERS+1 cycles, i.e. 33.
  - Special cases: 1 cycle, i.e. IDLE then DONE.
- Guarantee: DONE→IDLE coincides with ID_EX loading the next instruction, so the same instruction is never restarted.
- When in IDLE and the input is not typeMULDIV, stallReq_out=0.

Decomposition:
- The shared defines.vh gains:
  - `typeMULDIV
  - `idMUL, `idMULH, `idMULHSU, `idMULHU, `idDIV, `idDIVU, `idREM, `idREMU
  - FSM state encodings `mdIDLE/`mdBUSY/`mdDONE
- Sub-module muldiv_unit holds the FSM, counter and datapath.
  - Inputs: start, op, a, b, hold.
  - Outputs: busy, done, result.
- ex_stage holds the ALU, result mux and stall logic.

Test Plan:
- Reset: rst_in=0 for 2 cycles with a MUL presented → all outputs 0, stallReq_out=0; after release, the MUL starts fresh.
- ALU: ADD 0x7FFFFFFF+1 → 0x80000000. SRA 0x80000000 by 4 → 0xF8000000. SLTU 1<0xFFFFFFFF → 1. Each result lands the same cycle with rdE_out echoed.
- MUL family:
  - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE.
  - stallReq_out high exactly 33 cycles, result visible in DONE.
- Divide edges:
  - DIV 7/0 → 0xFFFFFFFF, latency 1.
  - REM 0x80000000 % -1 → 0.
  - DIV -7/2 → 0xFFFFFFFD; REM -7 % 2 → 0xFFFFFFFF.
- Downstream stall: hold stall_in[3]=Stall for 3 cycles during DONE → result and state held; IDLE entered on release; no restart.
- Reset mid-BUSY at cnt=10 → IDLE next edge, stallReq_out=0, no writeback produced.
